cmp_share_arbiter: RTL

//  Round-robin arbiter/sequencer sharing one unsigned W-bit magnitude comparator
//  (less/equal/greater) among NREQ requesters. Each requester presents an A/B pair

---
 rtl/cmp_share_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one unsigned magnitude comparator among NREQ requesters.
// Optional statistics counters (cnt_less/cnt_equal/cnt_greater) are enabled by defining CMP_ARB_STATS_EN.
module cmp_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 2,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    output logic [NREQ-1:0]   ack,
    output logic              res_valid,
    output logic [IDW-1:0]    res_id,
    output logic              less,
    output logic              equal,
    output logic              greater,
    output logic              busy
`ifdef CMP_ARB_STATS_EN
    ,
    output logic [7:0]        cnt_less,
    output logic [7:0]        cnt_equal,
    output logic [7:0]        cnt_greater
`endif
);

    localparam int PW = IDW + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_RESULT  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [IDW-1:0]  rr_ptr_q;
    logic [IDW-1:0]  gnt_id_q;
    logic [W-1:0]    a_q, b_q;
    logic            lt_q, eq_q, gt_q;
    logic            less_q, equal_q, greater_q;
    logic [IDW-1:0]  res_id_q;
    logic            res_valid_q;
    logic [NREQ-1:0] ack_q;

    logic [W-1:0]    a_arr [NREQ];
    logic [W-1:0]    b_arr [NREQ];
    logic [NREQ-1:0] gnt_onehot;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign a_arr[gi]      = a_in[gi*W +: W];
            assign b_arr[gi]      = b_in[gi*W +: W];
            assign gnt_onehot[gi] = (gnt_id_q == IDW'(gi));
        end
    endgenerate

    // First set request at or after rr_ptr, wrapping modulo NREQ.
    logic [IDW-1:0] gnt_d;
    logic           gnt_found;
    logic [PW-1:0]  scan_idx;
    logic [PW-1:0]  rr_ptr_inc;
    logic [IDW-1:0] rr_ptr_d;

    always_comb begin
        gnt_d     = '0;
        gnt_found = 1'b0;
        scan_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + PW'(k);
            if (scan_idx >= PW'(NREQ)) begin
                scan_idx = scan_idx - PW'(NREQ);
            end
            if (!gnt_found && req[scan_idx[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_d     = scan_idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        rr_ptr_inc = {1'b0, gnt_d} + PW'(1);
        rr_ptr_d   = rr_ptr_inc[IDW-1:0];
        if (rr_ptr_inc == PW'(NREQ)) begin
            rr_ptr_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (gnt_found) state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_RESULT;
            S_RESULT:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs update together with res_valid so a consumer sees a coherent result.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            gnt_id_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
            gt_q        <= 1'b0;
            less_q      <= 1'b0;
            equal_q     <= 1'b0;
            greater_q   <= 1'b0;
            res_id_q    <= '0;
            res_valid_q <= 1'b0;
            ack_q       <= '0;
        end else begin
            res_valid_q <= 1'b0;
            ack_q       <= '0;
            case (state_q)
                S_IDLE: begin
                    if (gnt_found) begin
                        gnt_id_q <= gnt_d;
                        a_q      <= a_arr[gnt_d];
                        b_q      <= b_arr[gnt_d];
                        rr_ptr_q <= rr_ptr_d;
                    end
                end
                S_CAPTURE: begin
                    lt_q <= (a_q < b_q);
                    eq_q <= (a_q == b_q);
                    gt_q <= (a_q > b_q);
                end
                S_RESULT: begin
                    less_q      <= lt_q;
                    equal_q     <= eq_q;
                    greater_q   <= gt_q;
                    res_id_q    <= gnt_id_q;
                    res_valid_q <= 1'b1;
                    ack_q       <= gnt_onehot;
                end
                default: ;
            endcase
        end
    end

`ifdef CMP_ARB_STATS_EN
    logic [7:0] cnt_less_q, cnt_equal_q, cnt_greater_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_less_q    <= '0;
            cnt_equal_q   <= '0;
            cnt_greater_q <= '0;
        end else if (state_q == S_RESULT) begin
            if (lt_q && cnt_less_q != 8'hFF)       cnt_less_q    <= cnt_less_q + 8'd1;
            if (eq_q && cnt_equal_q != 8'hFF)      cnt_equal_q   <= cnt_equal_q + 8'd1;
            if (gt_q && cnt_greater_q != 8'hFF)    cnt_greater_q <= cnt_greater_q + 8'd1;
        end
    end

    assign cnt_less    = cnt_less_q;
    assign cnt_equal   = cnt_equal_q;
    assign cnt_greater = cnt_greater_q;
`endif

    assign ack       = ack_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign less      = less_q;
    assign equal     = equal_q;
    assign greater   = greater_q;
    assign busy      = (state_q != S_IDLE);

endmodule
